// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator and the sequence detectors:
// FSM state encodings, default pattern geometry and a counter-width helper.
package seq_pkg;

    localparam int DEF_PAT_W = 5;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 5'b11010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_SEND = 3'b001,
        ST_GAP  = 3'b010,
        ST_DONE = 3'b011
    } state_t;

    // Bits needed to hold values 0 .. n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_down_ctr.sv
// Loadable down-counter with a zero flag. Load wins over decrement and the
// count saturates at zero. clr gives a synchronous clear distinct from reset.
module seq_down_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Count register: clear, load, or step down toward zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern generator: on start, sends a PAT_W-bit pattern MSB first,
// repeated R = max(repeat_n,1) times with GAP idle cycles between frames,
// followed by a one-cycle done pulse. abort and rst return it to IDLE.
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter int                 PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0]   PAT_DEF = DEF_PAT,
    parameter int                 GAP     = 2,
    parameter int                 REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] repeat_n,
    output logic             outp,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    localparam int BW = cnt_w(PAT_W);
    localparam int GW = cnt_w(GAP);

    localparam logic [BW-1:0] BIT_LOAD = BW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] shift_reg;

    logic [PAT_W-1:0] sel_pat;
    logic [REP_W-1:0] frame_load_val;

    logic bit_load, bit_dec, bit_zero;
    logic gap_load, gap_dec, gap_zero;
    logic frame_load, frame_dec, frame_zero;

    assign sel_pat        = use_def ? PAT_DEF : pattern;
    // Frames remaining after the first one; repeat_n of 0 behaves like 1.
    assign frame_load_val = (repeat_n == '0) ? '0 : repeat_n - REP_W'(1);
    assign state          = state_reg;

    // Counter control, derived from the same conditions the FSM uses.
    always_comb begin
        bit_load   = 1'b0;
        bit_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        frame_load = 1'b0;
        frame_dec  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    bit_load   = 1'b1;
                    frame_load = 1'b1;
                end
            end
            ST_SEND: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (!frame_zero) begin
                    frame_dec = 1'b1;
                    if (GAP > 0) begin
                        gap_load = 1'b1;
                    end else begin
                        bit_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    bit_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    seq_down_ctr #(.W(BW)) u_bit_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .load     (bit_load),
        .load_val (BIT_LOAD),
        .dec      (bit_dec),
        .zero     (bit_zero)
    );

    seq_down_ctr #(.W(GW)) u_gap_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    seq_down_ctr #(.W(REP_W)) u_frame_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .load     (frame_load),
        .load_val (frame_load_val),
        .dec      (frame_dec),
        .zero     (frame_zero)
    );

    // Main FSM with registered serial outputs; rst beats abort beats start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pat_reg   <= '0;
            shift_reg <= '0;
            outp      <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            outp      <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    outp  <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        pat_reg   <= sel_pat;
                        shift_reg <= sel_pat << 1;
                        outp      <= sel_pat[PAT_W-1];
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!bit_zero) begin
                        outp      <= shift_reg[PAT_W-1];
                        shift_reg <= shift_reg << 1;
                    end else if (!frame_zero) begin
                        if (GAP > 0) begin
                            outp      <= 1'b0;
                            valid     <= 1'b0;
                            state_reg <= ST_GAP;
                        end else begin
                            outp      <= pat_reg[PAT_W-1];
                            shift_reg <= pat_reg << 1;
                        end
                    end else begin
                        outp      <= 1'b0;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_zero) begin
                        outp      <= pat_reg[PAT_W-1];
                        shift_reg <= pat_reg << 1;
                        valid     <= 1'b1;
                        state_reg <= ST_SEND;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    outp      <= 1'b0;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: two instances (GAP=2 and GAP=0) share all inputs and
// are checked every cycle against a per-cycle expectation computed from the
// frame/gap timeline arithmetic.
module tb_seq_gen_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       use_def = 1'b0;
    logic [4:0] pattern = 5'b0;
    logic [3:0] repeat_n = 4'b0;

    logic       outp2, valid2, busy2, done2;
    logic [2:0] state2;
    logic       outp0, valid0, busy0, done0;
    logic [2:0] state0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_gen_tx #(.PAT_W(5), .PAT_DEF(5'b11010), .GAP(2), .REP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .use_def(use_def),
        .pattern(pattern), .repeat_n(repeat_n),
        .outp(outp2), .valid(valid2), .busy(busy2), .done(done2), .state(state2)
    );

    seq_gen_tx #(.PAT_W(5), .PAT_DEF(5'b11010), .GAP(0), .REP_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .use_def(use_def),
        .pattern(pattern), .repeat_n(repeat_n),
        .outp(outp0), .valid(valid0), .busy(busy0), .done(done0), .state(state0)
    );

    // Expected {state, done, busy, valid, outp} for cycle idx after the start edge.
    function automatic logic [6:0] exp_at(input logic [4:0] pat, input int r,
                                          input int gap, input int idx);
        int fl;
        int bl;
        int pos;
        fl = 5 + gap;
        bl = r * 5 + (r - 1) * gap;
        if (idx < bl) begin
            pos = idx % fl;
            if (pos < 5) return {3'b001, 1'b0, 1'b1, 1'b1, pat[4 - pos]};
            return {3'b010, 1'b0, 1'b1, 1'b0, 1'b0};
        end
        if (idx == bl) return {3'b011, 1'b1, 1'b0, 1'b0, 1'b0};
        return 7'b0;
    endfunction

    // One transfer: start with given inputs, then scramble inputs and compare
    // both instances each cycle; optional abort / reset at a given cycle.
    task automatic run_xfer(input string name, input logic [4:0] p, input logic ud,
                            input logic [3:0] rn, input int hold, input int abort_at,
                            input int rst_at, output int busy_cyc, output int det_cnt);
        logic [4:0] pat;
        logic [4:0] win;
        logic [6:0] e2, e0, a2, a0;
        int r;
        int stop;
        int len;
        pat      = ud ? 5'b11010 : p;
        r        = (rn == 4'd0) ? 1 : int'(rn);
        stop     = -1;
        len      = r * 5 + (r - 1) * 2 + 3;
        win      = 5'b0;
        busy_cyc = 0;
        det_cnt  = 0;
        @(negedge clk);
        pattern  = p;
        use_def  = ud;
        repeat_n = rn;
        start    = 1'b1;
        @(negedge clk);
        start    = (hold > 0);
        pattern  = 5'($urandom);
        use_def  = 1'($urandom);
        repeat_n = 4'($urandom);
        for (int i = 0; i < len; i++) begin
            if (stop >= 0 && i > stop) begin
                e2 = 7'b0;
                e0 = 7'b0;
            end else begin
                e2 = exp_at(pat, r, 2, i);
                e0 = exp_at(pat, r, 0, i);
            end
            a2 = {state2, done2, busy2, valid2, outp2};
            a0 = {state0, done0, busy0, valid0, outp0};
            tests += 2;
            if (a2 !== e2) begin
                fails++;
                $display("FAIL %s gap2 cyc %0d: got {st,done,busy,valid,outp}=%b want %b",
                         name, i, a2, e2);
            end
            if (a0 !== e0) begin
                fails++;
                $display("FAIL %s gap0 cyc %0d: got {st,done,busy,valid,outp}=%b want %b",
                         name, i, a0, e0);
            end
            if (busy2) busy_cyc++;
            win = {win[3:0], outp2};
            if (win == 5'b11010) det_cnt++;
            abort = 1'b0;
            rst   = 1'b0;
            if (i == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                stop  = i;
            end else if (i == rst_at) begin
                rst   = 1'b1;
                start = 1'b1;
                stop  = i;
            end else if (i + 1 >= hold || stop >= 0) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        $display("[TB] %s pat=%b use_def=%0d rep=%0d hold=%0d busy=%0d det=%0d",
                 name, pat, ud, rn, hold, busy_cyc, det_cnt);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({state2, done2, busy2, valid2, outp2, state0, done0, busy0, valid0, outp0} !== 14'b0) begin
            fails++;
            $display("FAIL reset: got %b %b want all zero",
                     {state2, done2, busy2, valid2, outp2}, {state0, done0, busy0, valid0, outp0});
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if ({state2, busy2, valid2, state0, busy0, valid0} !== 10'b0) begin
            fails++;
            $display("FAIL reset_idle: got state2=%b busy2=%b state0=%b busy0=%b want 0",
                     state2, busy2, state0, busy0);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_default_pattern();
        int b, d;
        run_xfer("default", 5'b00000, 1'b1, 4'd1, 0, -1, -1, b, d);
        tests++;
        if (b !== 5) begin
            fails++;
            $display("FAIL default_busy: got %0d want 5", b);
        end
    endtask

    task automatic test_loopback_detect();
        int b, d;
        run_xfer("loopback", 5'b01010, 1'b1, 4'd3, 3, -1, -1, b, d);
        tests += 2;
        if (b !== 19) begin
            fails++;
            $display("FAIL loopback_busy: got %0d want 19", b);
        end
        if (d !== 3) begin
            fails++;
            $display("FAIL loopback_detect: got %0d want 3", d);
        end
    endtask

    task automatic test_gap0_pattern();
        int b, d;
        run_xfer("gap0", 5'b10011, 1'b0, 4'd2, 0, -1, -1, b, d);
    endtask

    task automatic test_abort();
        int b, d;
        run_xfer("abort", 5'b10110, 1'b0, 4'd2, 4, 2, -1, b, d);
    endtask

    task automatic test_rst_mid_gap();
        int b, d;
        run_xfer("rst_gap", 5'b11101, 1'b0, 4'd3, 8, -1, 5, b, d);
    endtask

    task automatic test_repeat_zero();
        int b, d;
        run_xfer("rep0", 5'b01101, 1'b0, 4'd0, 0, -1, -1, b, d);
        tests++;
        if (b !== 5) begin
            fails++;
            $display("FAIL rep0_busy: got %0d want 5", b);
        end
    endtask

    task automatic test_random();
        int b, d, r, hold;
        logic [4:0] p;
        logic [3:0] rn;
        logic ud;
        for (int k = 0; k < 20; k++) begin
            p    = 5'($urandom);
            rn   = 4'($urandom);
            ud   = 1'($urandom);
            r    = (rn == 4'd0) ? 1 : int'(rn);
            hold = $urandom_range(0, r * 5);
            run_xfer("random", p, ud, rn, hold, -1, -1, b, d);
            tests++;
            if (b !== r * 5 + (r - 1) * 2) begin
                fails++;
                $display("FAIL random_busy: got %0d want %0d", b, r * 5 + (r - 1) * 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_pattern();
        test_loopback_detect();
        test_gap0_pattern();
        test_abort();
        test_rst_mid_gap();
        test_repeat_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
